// File: rtl/booth4_unidad_control.sv
// Control unit for the radix-4 Booth multiplier.
// Sequences SIZE/2 iterations of {evaluate, optional add/sub, 2-bit shift}
// and drives the load/shift/select lines of the datapath.
// Optional build macro BOOTH_CONTADOR_CICLOS_EN adds an 8-bit cycle counter
// output (ciclos) covering LOAD through DONE, saturating at 255.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for inicio, all outputs low
// S_LOAD  | carga_ini: load M/Q, clear A and Q[-1], clear iteration count
// S_EVAL  | decode {Q1,Q0,Q-1}; zero code skips straight to shift
// S_ADD   | carga_a with the resta/sel_m2 latched on entry
// S_SHIFT | desplaza; exit after the last iteration, else count up
// S_DONE  | fin pulse for one cycle
module booth4_unidad_control #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [2:0] q_bits,
  output logic       carga_ini,
  output logic       carga_a,
  output logic       resta,
  output logic       sel_m2,
  output logic       desplaza,
  output logic       ocupado,
  output logic       fin
`ifdef BOOTH_CONTADOR_CICLOS_EN
  ,
  output logic [7:0] ciclos
`endif
);

  // SIZE is expected to be even and >= 4
  localparam int ITER = SIZE / 2;
  localparam int CW = ($clog2(ITER) < 1) ? 1 : $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resta_q, resta_d;
  logic          sel_m2_q, sel_m2_d;

  // State, iteration counter and latched add/sub selects
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      resta_q  <= 1'b0;
      sel_m2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resta_q  <= resta_d;
      sel_m2_q <= sel_m2_d;
    end
  end

  // Next-state logic; selects are only loaded on the EVAL->ADD transition
  // so they read back as zero in every state other than ADD
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resta_d  = 1'b0;
    sel_m2_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inicio) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (q_bits == 3'b000 || q_bits == 3'b111) begin
          state_d = S_SHIFT;
        end else begin
          state_d  = S_ADD;
          resta_d  = q_bits[2];
          sel_m2_d = (q_bits == 3'b011) || (q_bits == 3'b100);
        end
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // exit test before the increment keeps cnt from wrapping
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_EVAL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign carga_ini = (state_q == S_LOAD);
  assign carga_a   = (state_q == S_ADD);
  assign resta     = resta_q;
  assign sel_m2    = sel_m2_q;
  assign desplaza  = (state_q == S_SHIFT);
  assign ocupado   = (state_q != S_IDLE);
  assign fin       = (state_q == S_DONE);

`ifdef BOOTH_CONTADOR_CICLOS_EN
  logic [7:0] ciclos_q, ciclos_d;

  // Counter tracks the number of cycles spent from LOAD up to the current one
  always_ff @(posedge clk) begin
    if (reset) ciclos_q <= 8'd0;
    else       ciclos_q <= ciclos_d;
  end

  // Restart on entry to LOAD, count on entry to any later busy state, hold in IDLE
  always_comb begin
    ciclos_d = ciclos_q;
    if (state_d == S_LOAD) begin
      ciclos_d = 8'd1;
    end else if (state_d != S_IDLE && ciclos_q != 8'hFF) begin
      ciclos_d = ciclos_q + 8'd1;
    end
  end

  assign ciclos = ciclos_q;
`endif

endmodule

// File: doc/booth4_unidad_control.md
Name: booth4_unidad_control

Overview:
- Sequencer (control unit) for the radix-4 Booth multiplier.
- Sits directly upstream of the datapath registers and sum/subtract unit. It drives their Carga/Desplaza lines, the add/subtract select and the M/2M mux select.
- Reads the three low multiplier bits {Q1,Q0,Q-1} each iteration, decides the Booth operation, and sequences SIZE/2 double-shift iterations.
- Signals completion to the surrounding system.

Parameters:
- SIZE, 4, operand width in bits. Must be even and >= 4. Iterations = SIZE/2.
- CW, derived (not overridable), iteration counter width = max(1, $clog2(SIZE/2)).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- inicio  input  1  start request, level-sampled only in IDLE
- q_bits  input  3  {Q[1],Q[0],Q[-1]} from multiplier register, valid in EVAL
- carga_ini  output  1  load M and Q from operands, clear A and Q[-1]
- carga_a  output  1  load A from sum/subtract result
- resta  output  1  1 = A-M or A-2M, 0 = A+M or A+2M
- sel_m2  output  1  mux select, 1 = 2M, 0 = M
- desplaza  output  1  2-bit arithmetic right shift of A:Q:Q[-1]
- ocupado  output  1  high whenever state != IDLE
- fin  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - reset is synchronous, active-high: on a rising clk edge with reset=1 the state goes to IDLE and cnt to 0.
  - All outputs are 0 from the first edge with reset=1. This overrides any other event.
- Outputs are Moore-decoded from state. resta and sel_m2 are registered with the ADD transition and are 0 outside ADD.
- States, one clk cycle each:
  - IDLE: all outputs 0. If inicio=1, go to LOAD. Else stay.
  - LOAD: carga_ini=1, cnt<=0, go to EVAL.
  - EVAL: decode q_bits.
    - 000 or 111: go to SHIFT.
    - Otherwise: go to ADD, latching resta/sel_m2 per the decode table below.
  - ADD: carga_a=1 with the latched resta/sel_m2. Go to SHIFT.
  - SHIFT: desplaza=1.
    - If cnt == SIZE/2-1, go to DONE.
    - Else cnt<=cnt+1 and go to EVAL.
  - DONE: fin=1, go to IDLE.
- Booth decode (q_bits -> op, resta, sel_m2):
  - 001, 010 -> +M (0,0)
  - 011 -> +2M (0,1)
  - 100 -> -2M (1,1)
  - 101, 110 -> -M (1,0)
- Never asserted together in the same cycle: carga_ini, carga_a, desplaza.
- Latency:
  - inicio sampled at edge E0; LOAD occupies cycle 1.
  - Each iteration takes 2 cycles (zero code) or 3 cycles (non-zero code).
  - fin is high in cycle 1 + sum(iteration cycles) + 1.
  - SIZE=4: 6 cycles minimum, 8 cycles maximum.
- Boundary conditions:
  - inicio while ocupado=1: ignored.
  - inicio still high in the cycle after DONE (IDLE): starts a new operation immediately.
  - reset mid-operation: returns to IDLE next edge. No fin pulse is issued and the datapath is not touched further.
  - q_bits is ignored in every state except EVAL.
  - cnt never wraps: the exit test is done before the increment.

Optional Feature:
- Macro: BOOTH_CONTADOR_CICLOS_EN.
- Defined:
  - Adds output ciclos [7:0].
  - Cleared to 1 in LOAD, incremented by 1 each cycle through DONE inclusive, saturating at 255.
  - Holds its value in IDLE until the next LOAD.
  - 0 after reset.
  - SIZE=4 all-zero codes gives ciclos=6 after fin.
- Not defined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset then idle: reset=1 for 2 edges, inicio=0 -> all outputs 0, ocupado=0. Hold 5 cycles -> unchanged.
- SIZE=4, q_bits=000 at both EVALs, inicio pulsed 1 cycle -> state sequence LOAD, EVAL, SHIFT, EVAL, SHIFT, DONE.
  - fin=1 exactly in cycle 6.
  - desplaza high in cycles 3 and 5.
  - carga_a never high.
- SIZE=4, first EVAL q_bits=011, second EVAL q_bits=100:
  - cycle 3 carga_a=1, resta=0, sel_m2=1.
  - cycle 6 carga_a=1, resta=1, sel_m2=1.
  - fin in cycle 8.
- Full decode sweep: for each of the 8 q_bits values in the first EVAL, the next cycle's {carga_a, resta, sel_m2} matches the decode table. Values 000/111 go straight to desplaza=1.
- reset asserted in the ADD cycle of an operation -> next cycle all outputs 0, ocupado=0, no fin. Next inicio then runs a full clean sequence.
- inicio held high continuously, SIZE=4, all-zero codes:
  - fin in cycle 6, LOAD again in cycle 8.
  - No second LOAD between cycles 2 and 6.
  - With BOOTH_CONTADOR_CICLOS_EN: ciclos=6 in cycle 7, resets to 1 in cycle 8.
